rr_ring_arbiter: RTL
====================

// Module: rr_ring_arbiter
// PURPOSE
//   Round-robin arbiter that shares one resource between N requesters.
//   Priority is held in a one-hot ring pointer: bit 0 after reset, rotating one past each owner.
//   A hold timer preempts an owner after MAX_HOLD cycles, but only if another requester waits.
//   It sits in front of shared datapath blocks (counters, registers) and drives their select and enable lines.
// PARAMETERS
//   N         3   number of requesters, >= 2
//   MAX_HOLD  4   max consecutive grant cycles before preemption; 0 = never preempt
//   IDW       $clog2(N) (localparam)  width of grant_id
// PORTS
//   clk       in   1    clock; all state updates on the rising edge
//   rst       in   1    synchronous, active-high reset
//   req       in   N    request vector; bit i = requester i wants the resource
//   grant     out  N    registered one-hot grant, or all zero
//   grant_id  out  IDW  binary index of the granted requester; 0 when grant == 0
//   busy      out  1    1 when grant != 0
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): grant=0, grant_id=0, busy=0, ptr=1 (bit 0), hold_cnt=0, state=IDLE.
//   rst overrides everything, including mid-grant: the grant drops on the next edge.
//   Selection: scan ptr, ptr+1, ... modulo N; the first asserted req bit wins.
//   Latency: a req sampled at edge k drives grant after edge k; one cycle, no combinational path req->grant.
//   State IDLE (grant=0):
//     - req==0: stay IDLE.
//     - req!=0: grant the winner, hold_cnt=0, go to OWN.
//   State OWN (owner o, grant=1<<o), at each edge:
//     - req[o]==0 (release): set ptr=rotl(1<<o,1); arbitrate req with the new ptr in the same edge.
//       If there is a winner, grant it with hold_cnt=0 and no idle gap. Otherwise grant=0 and go to IDLE.
//     - req[o]==1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, other req bits set (preempt):
//       ptr=rotl(1<<o,1); grant the winner among req & ~(1<<o); hold_cnt=0.
//     - req[o]==1, timer expired, no other req: keep o, hold_cnt=0 (restart the window).
//     - Otherwise: keep o, hold_cnt+=1.
//   ptr moves only on release or preemption, never while IDLE.
//   A requester cannot be granted twice in a row while another waits.
//   Worst-case wait for requester i is (N-1)*MAX_HOLD cycles, plus 1 cycle of latency.
//   A req bit that drops before it is granted is simply not selected; this is not an error.
//   hold_cnt is ceil(log2(MAX_HOLD+1)) bits wide (min 1) and never wraps past MAX_HOLD-1.
//   Invariant: grant is one-hot or zero; grant_id == index(grant); busy == |grant.
// TESTING (N=3, MAX_HOLD=4 unless stated)
//   1 Reset: rst=1 for 2 cycles with req=3'b111 -> grant=000, busy=0; after release grant=001 one cycle later.
//   2 Rotation: req=111 held; owners release by pulsing their req low for 1 cycle.
//     -> grant sequence 001,010,100,001 with no idle cycle between owners.
//   3 Preemption: req=011 held constant -> grant=001 for 4 cycles, then 010 for 4 cycles, repeating.
//   4 Lone owner: req=100 held 20 cycles -> grant=100 continuously, grant_id=2, never drops.
//   5 Release to idle: req=010 for 2 cycles, then 000 -> grant=010 for 2 cycles, then 000, busy=0.
//     Next req=111 -> grant=100 (ptr advanced past 1).
//   6 Mid-op reset: rst=1 during grant=010 with req=111 -> grant=000 next edge.
//     After rst drops: grant=001 (ptr back at bit 0).
//   All tests: checker asserts the invariant every cycle; random req test (MAX_HOLD=0 and 4) checks no starvation.

Source files
------------

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot ring pointer and a hold timer that
// preempts a long-running owner only when another requester is waiting.
module rr_ring_arbiter #(
  parameter  int N        = 3,
  parameter  int MAX_HOLD = 4,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy
);

  // state | meaning
  // IDLE  | no owner, grant == 0, waiting for any req
  // OWN   | grant one-hot on the current owner, hold timer running
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int HCW_RAW = $clog2(MAX_HOLD + 1);
  localparam int HCW     = (HCW_RAW < 1) ? 1 : HCW_RAW;
  localparam bit PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t          state, state_n;
  logic [N-1:0]    ptr, ptr_n;
  logic [HCW-1:0]  hold_cnt, hold_n;
  logic [N-1:0]    grant_n;
  logic [IDW-1:0]  grant_id_n;
  logic [N-1:0]    nxt_ptr;
  logic [N-1:0]    others;
  logic            own_req;

  // First set bit of r at or above the one-hot pointer p, wrapping to bit 0.
  function automatic logic [N-1:0] pick(input logic [N-1:0] r, input logic [N-1:0] p);
    logic [N-1:0] mask;
    logic [N-1:0] hi;
    logic [N-1:0] sel;
    mask = ~(p - N'(1));
    hi   = r & mask;
    sel  = (|hi) ? hi : r;
    return sel & (~sel + N'(1));
  endfunction

  function automatic logic [IDW-1:0] to_idx(input logic [N-1:0] oh);
    logic [IDW-1:0] id;
    id = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) id = id | IDW'(i);
    end
    return id;
  endfunction

  function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
    return {v[N-2:0], v[N-1]};
  endfunction

  assign nxt_ptr = rotl1(grant);
  assign others  = req & ~grant;
  assign own_req = |(req & grant);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    grant_n = grant;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_n = pick(req, ptr);
          hold_n  = '0;
          state_n = OWN;
        end
      end
      OWN: begin
        if (!own_req) begin
          // Release: hand over in the same edge, no idle gap if anyone waits.
          ptr_n   = nxt_ptr;
          grant_n = pick(req, nxt_ptr);
          hold_n  = '0;
          state_n = (|req) ? OWN : IDLE;
        end else if (PREEMPT_EN && (hold_cnt == HOLD_LAST)) begin
          hold_n = '0;
          if (|others) begin
            ptr_n   = nxt_ptr;
            grant_n = pick(others, nxt_ptr);
          end
        end else if (PREEMPT_EN) begin
          hold_n = hold_cnt + HCW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        hold_n  = '0;
      end
    endcase
    grant_id_n = to_idx(grant_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= N'(1);
      hold_cnt <= '0;
      grant    <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      grant    <= grant_n;
      grant_id <= grant_id_n;
    end
  end

  assign busy = |grant;

endmodule
